// File: rtl/rr_sched_pkg.sv
// Shared types and helpers for the round-robin grant scheduler.
package rr_sched_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   localparam int DEF_NUM_REQ   = 4;
   localparam int DEF_MAX_BURST = 8;

   // Binary index of the set bit of a one-hot vector; 0 for an all-zero vector.
   function automatic int unsigned onehot_to_index(input logic [31:0] vec);
      int unsigned idx;
      idx = 32'd0;
      for (int unsigned i = 0; i < 32; i++) begin
         idx = idx | (vec[i] ? i : 32'd0);
      end
      return idx;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational circular priority picker: first set req bit at or above ptr, wrapping.
module rr_pick
   import rr_sched_pkg::*;
#(
   parameter int N = DEF_NUM_REQ
) (
   input  logic [N-1:0] req,
   input  logic [N-1:0] ptr,
   output logic [N-1:0] pick,
   output logic         found
);

   localparam int IW = $clog2(N);

   logic [IW-1:0] base;
   logic [IW-1:0] idx;
   logic          hit;

   // Walk N positions from the pointer; index arithmetic wraps because N is a power of two.
   always_comb begin
      base  = '0;
      idx   = '0;
      hit   = 1'b0;
      pick  = '0;
      found = 1'b0;
      for (int i = 0; i < N; i++) begin
         base = base | (ptr[i] ? IW'(i) : '0);
      end
      for (int off = 0; off < N; off++) begin
         idx       = base + IW'(off);
         hit       = req[idx] & ~found;
         pick[idx] = hit;
         found     = found | hit;
      end
   end

endmodule

// File: rtl/rr_grant_scheduler.sv
// Round-robin scheduler with registered one-hot grant and binary grant id.
// Optional burst limit enabled by defining BURST_LIMIT_EN.
module rr_grant_scheduler
   import rr_sched_pkg::*;
#(
   parameter int NUM_REQ   = DEF_NUM_REQ,
   parameter int ID_W      = 2,
   parameter int MAX_BURST = DEF_MAX_BURST,
   parameter int CNT_W     = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] req,
   output logic [NUM_REQ-1:0] grant,
   output logic [ID_W-1:0]    grant_id,
   output logic               grant_valid
);

   if (ID_W != $clog2(NUM_REQ) || CNT_W < $clog2(MAX_BURST)) begin : g_cfg_check
      $error("rr_grant_scheduler: inconsistent ID_W/CNT_W parameters");
   end

   state_t             state;
   state_t             state_nxt;
   logic [NUM_REQ-1:0] ptr;
   logic [NUM_REQ-1:0] grant_nxt;
   logic [NUM_REQ-1:0] pick_req;
   logic [NUM_REQ-1:0] pick;
   logic               found;
   logic               owner_req;
   logic               new_grant;
   logic               preempt;

`ifdef BURST_LIMIT_EN
   logic [CNT_W-1:0]   cnt;
   logic               cnt_max;

   assign cnt_max = (cnt == CNT_W'(MAX_BURST - 1));
   assign preempt = cnt_max & found;
`else
   assign preempt = 1'b0;
`endif

   // The owner is masked out so a burst rotation never re-picks it.
   assign pick_req  = (state == GRANT) ? (req & ~grant) : req;
   assign owner_req = |(req & grant);

   rr_pick #(.N(NUM_REQ)) u_pick (
      .req   (pick_req),
      .ptr   (ptr),
      .pick  (pick),
      .found (found)
   );

   // Next-state and next-grant decision.
   always_comb begin
      state_nxt = state;
      grant_nxt = grant;
      new_grant = 1'b0;
      case (state)
         IDLE: begin
            if (found) begin
               new_grant = 1'b1;
            end else begin
               grant_nxt = '0;
            end
         end
         GRANT: begin
            if (!owner_req || preempt) begin
               if (found) begin
                  new_grant = 1'b1;
               end else begin
                  state_nxt = IDLE;
                  grant_nxt = '0;
               end
            end else begin
               grant_nxt = grant;
            end
         end
         default: begin
            state_nxt = IDLE;
            grant_nxt = '0;
         end
      endcase
      if (new_grant) begin
         state_nxt = GRANT;
         grant_nxt = pick;
      end else begin
         grant_nxt = grant_nxt;
      end
   end

   // State, pointer and registered grant outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         ptr         <= {{(NUM_REQ-1){1'b0}}, 1'b1};
         grant       <= '0;
         grant_id    <= '0;
         grant_valid <= 1'b0;
      end else begin
         state       <= state_nxt;
         grant       <= grant_nxt;
         grant_id    <= ID_W'(onehot_to_index(32'(grant_nxt)));
         grant_valid <= |grant_nxt;
         if (new_grant) begin
            ptr <= {pick[NUM_REQ-2:0], pick[NUM_REQ-1]};
         end else begin
            ptr <= ptr;
         end
      end
   end

`ifdef BURST_LIMIT_EN
   // Burst counter: cleared on each new grant, saturates at MAX_BURST-1 while held.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (new_grant) begin
         cnt <= '0;
      end else if (state == GRANT && owner_req && !cnt_max) begin
         cnt <= cnt + CNT_W'(1);
      end else begin
         cnt <= cnt;
      end
   end
`endif

endmodule

// File: tb/tb_rr_grant_scheduler.sv
// Directed and random-traffic self-checking bench for rr_grant_scheduler.
module tb_rr_grant_scheduler;

   localparam int N   = 4;
   localparam int MAXB = 8;

   logic         clk;
   logic         rst;
   logic [N-1:0] req;
   logic [N-1:0] grant;
   logic [1:0]   grant_id;
   logic         grant_valid;

   int checks   = 0;
   int failures = 0;

   // reference model state for random traffic
   logic [N-1:0] m_grant;
   int           m_ptr;
   int           m_cnt;
   logic [N-1:0] prev_req;

   rr_grant_scheduler dut (
      .clk         (clk),
      .rst         (rst),
      .req         (req),
      .grant       (grant),
      .grant_id    (grant_id),
      .grant_valid (grant_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_out(input string tag, input logic [N-1:0] g, input logic [1:0] id);
      check_eq({tag, "_grant"}, 32'(grant), 32'(g));
      check_eq({tag, "_id"}, 32'(grant_id), 32'(id));
      check_eq({tag, "_valid"}, 32'(grant_valid), 32'(|g));
   endtask

   task automatic do_reset();
      rst = 1'b0;
      step();
      step();
      rst = 1'b1;
   endtask

   // One edge of the reference arbiter, using the request seen at that edge.
   task automatic model_edge(input logic [N-1:0] r);
      int  owner;
      bit  others;
      bit  hold;
      bit  done;
      owner = -1;
      for (int i = 0; i < N; i++) if (m_grant[i]) owner = i;
      others = ((r & ~m_grant) != '0);
      hold = 1'b0;
      if (owner >= 0 && r[owner]) begin
         hold = 1'b1;
`ifdef BURST_LIMIT_EN
         if (m_cnt == MAXB - 1 && others) hold = 1'b0;
`endif
      end
      if (hold) begin
         if (m_cnt < MAXB - 1) m_cnt++;
      end else begin
         done = 1'b0;
         m_grant = '0;
         for (int k = 0; k < N; k++) begin
            int j;
            j = (m_ptr + k) % N;
            if (!done && r[j] && j != owner) begin
               m_grant = N'(1) << j;
               m_ptr = (j + 1) % N;
               m_cnt = 0;
               done = 1'b1;
            end
         end
      end
   endtask

   initial begin
      logic [N-1:0] exp_g;
      logic [1:0]   exp_id;
      rst = 1'b0;
      req = '0;
      #2;
      check_out("reset_init", 4'b0000, 2'd0);
      do_reset();

      // sole requester 0: grant after one edge, held, dropped one edge after release
      req = 4'b0001;
      step();
      check_out("t2_grant", 4'b0001, 2'd0);
      for (int c = 0; c < 3; c++) begin
         step();
         check_out("t2_hold", 4'b0001, 2'd0);
      end
      req = 4'b0000;
      step();
      check_out("t2_release", 4'b0000, 2'd0);

      // two requesters from idle, then handover with no idle cycle
      req = 4'b0110;
      step();
      check_out("t3_first", 4'b0010, 2'd1);
      req = 4'b0100;
      step();
      check_out("t3_handover", 4'b0100, 2'd2);
      req = 4'b0000;
      step();
      check_out("t3_idle", 4'b0000, 2'd0);

      // ptr is at bit 3: owner 3, release wraps to 0, ptr becomes bit 1
      req = 4'b1001;
      step();
      check_out("t4_owner3", 4'b1000, 2'd3);
      req = 4'b0001;
      step();
      check_out("t4_wrap", 4'b0001, 2'd0);
      req = 4'b0000;
      step();
      check_out("t4_idle", 4'b0000, 2'd0);
      req = 4'b0011;
      step();
      check_out("t4_ptr_bit1", 4'b0010, 2'd1);

      // asynchronous reset mid-cycle during a grant
      req = 4'b1111;
      step();
      #3;
      rst = 1'b0;
      #1;
      check_out("t1_async_rst", 4'b0000, 2'd0);
      step();
      rst = 1'b1;
      step();
      check_out("t1_restart_bit0", 4'b0001, 2'd0);

      // sustained two-requester traffic: burst rotation or indefinite hold
      do_reset();
      req = 4'b0011;
      for (int c = 0; c < 3 * MAXB; c++) begin
         step();
`ifdef BURST_LIMIT_EN
         exp_g  = ((c / MAXB) % 2 == 0) ? 4'b0001 : 4'b0010;
         exp_id = ((c / MAXB) % 2 == 0) ? 2'd0 : 2'd1;
`else
         exp_g  = 4'b0001;
         exp_id = 2'd0;
`endif
         check_out("t5_burst", exp_g, exp_id);
      end

      // random traffic against the reference model
      req = '0;
      do_reset();
      m_grant = '0;
      m_ptr   = 0;
      m_cnt   = 0;
      for (int c = 0; c < 300; c++) begin
         if ($urandom_range(0, 2) == 0) req = req ^ N'($urandom_range(0, 15));
         prev_req = req;
         @(posedge clk);
         model_edge(prev_req);
         #1;
         check_eq("rnd_onehot0", 32'($onehot0(grant)), 32'd1);
         check_eq("rnd_req_held", 32'(grant & ~prev_req), 32'd0);
         check_out("rnd_model", m_grant, 2'(onehot_idx(m_grant)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   function automatic int onehot_idx(input logic [N-1:0] v);
      int r;
      r = 0;
      for (int i = 0; i < N; i++) if (v[i]) r = i;
      return r;
   endfunction

endmodule
